// File: rtl/stack_binop_pkg.sv
// Shared codes for the binary-op sequencer: opcodes, trap codes, the stack's
// op/status encodings and the sequencer state type.
package stack_binop_pkg;

    typedef enum logic [3:0] {
        BINOP_ADD   = 4'd0,
        BINOP_SUB   = 4'd1,
        BINOP_AND   = 4'd2,
        BINOP_OR    = 4'd3,
        BINOP_XOR   = 4'd4,
        BINOP_SHL   = 4'd5,
        BINOP_SHR_U = 4'd6,
        BINOP_SHR_S = 4'd7,
        BINOP_EQ    = 4'd8,
        BINOP_NE    = 4'd9,
        BINOP_LT_U  = 4'd10,
        BINOP_LT_S  = 4'd11
    } binop_e;

    typedef enum logic [1:0] {
        TRAP_NONE      = 2'd0,
        TRAP_UNDERFLOW = 2'd1,
        TRAP_BADOP     = 2'd2
    } trap_e;

    typedef enum logic [1:0] {
        STACK_OP_NONE    = 2'd0,
        STACK_OP_PUSH    = 2'd1,
        STACK_OP_POP     = 2'd2,
        STACK_OP_REPLACE = 2'd3
    } stack_op_e;

    typedef enum logic [1:0] {
        STACK_ST_NONE      = 2'd0,
        STACK_ST_EMPTY     = 2'd1,
        STACK_ST_UNDERFLOW = 2'd2,
        STACK_ST_OVERFLOW  = 2'd3
    } stack_status_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_POP,
        S_EVAL,
        S_WRITE
    } state_e;

    // Codes above BINOP_LT_S are reserved and trap as BADOP.
    function automatic logic binop_valid(input logic [3:0] op);
        return op <= BINOP_LT_S;
    endfunction

endpackage

// File: rtl/stack_binop_if.sv
// Decoder/stack-facing signals of stack_binop. The slave side is the
// sequencer; the master side is the decoder plus the attached stack.
interface stack_binop_if #(parameter int WIDTH = 8);

    logic             start;
    logic [3:0]       opcode;
    logic             busy;
    logic             done;
    logic [1:0]       trap;
    logic [1:0]       stack_op;
    logic [WIDTH-1:0] stack_data;
    logic [WIDTH-1:0] stack_tos;
    logic [1:0]       stack_status;

    modport master (
        output start, opcode, stack_tos, stack_status,
        input  busy, done, trap, stack_op, stack_data
    );

    modport slave (
        input  start, opcode, stack_tos, stack_status,
        output busy, done, trap, stack_op, stack_data
    );

endinterface

// File: rtl/stack_binop_alu.sv
// Combinational ALU for the WebAssembly-style binary ops: result = a op b,
// WIDTH-bit wrap-around; comparisons yield zero-extended 0/1.
module binop_alu
    import stack_binop_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [3:0]       opcode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result
);

    logic [WIDTH-1:0] shamt;

    assign shamt = b % WIDTH'(WIDTH);

    always_comb begin
        result = '0;
        unique case (binop_e'(opcode))
            BINOP_ADD:   result = a + b;
            BINOP_SUB:   result = a - b;
            BINOP_AND:   result = a & b;
            BINOP_OR:    result = a | b;
            BINOP_XOR:   result = a ^ b;
            BINOP_SHL:   result = a << shamt;
            BINOP_SHR_U: result = a >> shamt;
            BINOP_SHR_S: result = $signed(a) >>> shamt;
            BINOP_EQ:    result = WIDTH'(a == b);
            BINOP_NE:    result = WIDTH'(a != b);
            BINOP_LT_U:  result = WIDTH'(a < b);
            BINOP_LT_S:  result = WIDTH'($signed(a) < $signed(b));
            default:     result = '0;
        endcase
    end

endmodule

// File: rtl/stack_binop.sv
// Sequencer executing one binary op on the operand stack: POP b, then
// REPLACE the new top a with alu(a, b). Traps on underflow or bad opcode.
module stack_binop
    import stack_binop_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic          clk,
    input  logic          reset,
    stack_binop_if.slave  bus
);

    state_e           state;
    logic [3:0]       op_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] alu_res;
    logic             busy_q;
    logic             done_q;
    trap_e            trap_q;
    stack_op_e        stack_op_q;
    logic [WIDTH-1:0] stack_data_q;

    binop_alu #(.WIDTH(WIDTH)) u_alu (
        .opcode (op_q),
        .a      (bus.stack_tos),
        .b      (b_q),
        .result (alu_res)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            op_q         <= '0;
            b_q          <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            trap_q       <= TRAP_NONE;
            stack_op_q   <= STACK_OP_NONE;
            stack_data_q <= '0;
        end else begin
            done_q <= 1'b0;
            trap_q <= TRAP_NONE;
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        if (binop_valid(bus.opcode)) begin
                            op_q       <= bus.opcode;
                            b_q        <= bus.stack_tos;
                            stack_op_q <= STACK_OP_POP;
                            busy_q     <= 1'b1;
                            state      <= S_POP;
                        end else begin
                            done_q <= 1'b1;
                            trap_q <= TRAP_BADOP;
                        end
                    end
                end
                S_POP: begin
                    stack_op_q <= STACK_OP_NONE;
                    state      <= S_EVAL;
                end
                S_EVAL: begin
                    // EMPTY after the pop means only b was on the stack.
                    if (bus.stack_status == STACK_ST_UNDERFLOW ||
                        bus.stack_status == STACK_ST_EMPTY) begin
                        done_q <= 1'b1;
                        trap_q <= TRAP_UNDERFLOW;
                        busy_q <= 1'b0;
                        state  <= S_IDLE;
                    end else begin
                        stack_data_q <= alu_res;
                        stack_op_q   <= STACK_OP_REPLACE;
                        state        <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    stack_op_q <= STACK_OP_NONE;
                    done_q     <= 1'b1;
                    busy_q     <= 1'b0;
                    state      <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.trap       = trap_q;
    assign bus.stack_op   = stack_op_q;
    assign bus.stack_data = stack_data_q;

endmodule

// File: tb/tb_stack_binop.sv
// Bench for stack_binop: a 2-entry behavioural stack, a queue-based reference
// model with a per-cycle output timeline, directed cases and random requests.
module tb_stack_binop;
    import stack_binop_pkg::*;

    localparam int K_OK  = 0;
    localparam int K_UF  = 1;
    localparam int K_BAD = 2;

    logic clk = 1'b0;
    logic reset;
    stack_binop_if #(.WIDTH(8)) bus ();

    stack_binop #(.WIDTH(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Attached stack: two entries, tos reads 0 when empty.
    logic [1:0] tb_op;
    logic [7:0] tb_data;
    logic [1:0] eff_op;
    logic [7:0] eff_data;
    logic [7:0] smem [2];
    int         scnt;
    logic [1:0] sst;

    assign eff_op   = (bus.stack_op != STACK_OP_NONE) ? bus.stack_op : tb_op;
    assign eff_data = (bus.stack_op != STACK_OP_NONE) ? bus.stack_data : tb_data;

    always @(posedge clk) begin
        if (reset) begin
            scnt <= 0;
            sst  <= STACK_ST_EMPTY;
        end else begin
            case (eff_op)
                STACK_OP_PUSH:
                    if (scnt < 2) begin
                        smem[scnt] <= eff_data;
                        scnt <= scnt + 1;
                        sst  <= STACK_ST_NONE;
                    end else sst <= STACK_ST_OVERFLOW;
                STACK_OP_POP:
                    if (scnt == 0) sst <= STACK_ST_UNDERFLOW;
                    else begin
                        scnt <= scnt - 1;
                        sst  <= (scnt == 1) ? STACK_ST_EMPTY : STACK_ST_NONE;
                    end
                STACK_OP_REPLACE:
                    if (scnt == 0) sst <= STACK_ST_UNDERFLOW;
                    else begin
                        smem[scnt-1] <= eff_data;
                        sst <= STACK_ST_NONE;
                    end
                default: ;
            endcase
        end
    end

    assign bus.stack_tos    = (scnt > 0) ? smem[scnt-1] : 8'h00;
    assign bus.stack_status = sst;

    // Reference model state
    int   q[$];
    int   exp_st;
    bit   mon_en     = 1'b0;
    bit   req_active = 1'b0;
    int   req_kind;
    int   req_res;
    int   t0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int alu_ref(input int op, input int a, input int b);
        int sa, sb, sh, p, r;
        sa = (a >= 128) ? a - 256 : a;
        sb = (b >= 128) ? b - 256 : b;
        sh = b % 8;
        p  = 1 << sh;
        r  = 0;
        case (op)
            0:  r = a + b;
            1:  r = a - b;
            2:  r = a & b;
            3:  r = a | b;
            4:  r = a ^ b;
            5:  r = a * p;
            6:  r = a / p;
            7:  r = (sa >= 0) ? sa / p : -((-sa + p - 1) / p);
            8:  r = (a == b) ? 1 : 0;
            9:  r = (a != b) ? 1 : 0;
            10: r = (a < b) ? 1 : 0;
            11: r = (sa < sb) ? 1 : 0;
            default: r = 0;
        endcase
        return r & 255;
    endfunction

    // Every cycle: outputs against the request timeline (k = edges after E0).
    always @(negedge clk) begin
        int k, eo, eb, ed, et;
        if (mon_en) begin
            k  = req_active ? cyc - t0 : -1;
            eo = STACK_OP_NONE; eb = 0; ed = 0; et = TRAP_NONE;
            if (k >= 0) begin
                case (req_kind)
                    K_OK: begin
                        eo = (k == 0) ? STACK_OP_POP : (k == 2) ? STACK_OP_REPLACE : STACK_OP_NONE;
                        eb = (k <= 2) ? 1 : 0;
                        ed = (k == 3) ? 1 : 0;
                    end
                    K_UF: begin
                        eo = (k == 0) ? STACK_OP_POP : STACK_OP_NONE;
                        eb = (k <= 1) ? 1 : 0;
                        ed = (k == 2) ? 1 : 0;
                        et = (k == 2) ? TRAP_UNDERFLOW : TRAP_NONE;
                    end
                    default: begin
                        ed = (k == 0) ? 1 : 0;
                        et = (k == 0) ? TRAP_BADOP : TRAP_NONE;
                    end
                endcase
            end
            chk("done", 32'(bus.done), 32'(ed));
            chk("busy", 32'(bus.busy), 32'(eb));
            chk("trap", 32'(bus.trap), 32'(et));
            chk("stack_op", 32'(bus.stack_op), 32'(eo));
            if (req_active && req_kind == K_OK && k == 2)
                chk("stack_data", 32'(bus.stack_data), 32'(req_res));
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic clear();
        reset = 1'b1;
        step();
        reset = 1'b0;
        q.delete();
        exp_st = STACK_ST_EMPTY;
    endtask

    task automatic push(input int v);
        tb_op   = STACK_OP_PUSH;
        tb_data = 8'(v);
        step();
        tb_op = STACK_OP_NONE;
        q.push_back(v & 255);
        exp_st = STACK_ST_NONE;
    endtask

    task automatic do_req(input int opc, input bit noise);
        int kind, fk;
        if (opc >= 12) begin kind = K_BAD; fk = 0; end
        else if (q.size() < 2) begin kind = K_UF; fk = 2; end
        else begin kind = K_OK; fk = 3; end
        req_res = (kind == K_OK) ? alu_ref(opc, q[q.size()-2], q[q.size()-1]) : 0;
        req_kind   = kind;
        t0         = cyc + 1;
        req_active = 1'b1;
        bus.start  = 1'b1;
        bus.opcode = 4'(opc);
        step();
        bus.start  = noise && (kind != K_BAD);
        bus.opcode = 4'($urandom);
        for (int i = 0; i < fk; i++) begin
            step();
            bus.start = 1'b0;
        end
        bus.start = 1'b0;
        case (kind)
            K_OK: begin
                void'(q.pop_back());
                q[q.size()-1] = req_res;
                exp_st = STACK_ST_NONE;
            end
            K_UF: begin
                if (q.size() == 1) begin
                    void'(q.pop_back());
                    exp_st = STACK_ST_EMPTY;
                end else exp_st = STACK_ST_UNDERFLOW;
            end
            default: ;
        endcase
        chk("final_tos", 32'(bus.stack_tos), (q.size() > 0) ? 32'(q[q.size()-1]) : 32'd0);
        chk("final_status", 32'(bus.stack_status), 32'(exp_st));
        req_active = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        bus.start = 1'b0;
        bus.opcode = '0;
        tb_op = STACK_OP_NONE;
        tb_data = '0;
        reset = 1'b1;
        exp_st = STACK_ST_EMPTY;
        step();
        step();
        mon_en = 1'b1;
        chk("rst_stack_data", 32'(bus.stack_data), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        reset = 1'b0;

        push(3); push(5); do_req(BINOP_SUB, 1'b1);
        chk("sub_tos", 32'(bus.stack_tos), 32'hFE);
        chk("sub_status", 32'(bus.stack_status), 32'(STACK_ST_NONE));

        clear(); push('h80); push(1); do_req(BINOP_SHR_S, 1'b0);
        chk("shr_s_tos", 32'(bus.stack_tos), 32'hC0);
        clear(); push('h80); push(1); do_req(BINOP_SHR_U, 1'b0);
        chk("shr_u_tos", 32'(bus.stack_tos), 32'h40);
        clear(); push('h80); push(9); do_req(BINOP_SHR_S, 1'b0);
        chk("shr_s9_tos", 32'(bus.stack_tos), 32'hC0);

        clear(); push('hFF); push(1); do_req(BINOP_LT_S, 1'b0);
        chk("lt_s_tos", 32'(bus.stack_tos), 32'h01);
        clear(); push('hFF); push(1); do_req(BINOP_LT_U, 1'b0);
        chk("lt_u_tos", 32'(bus.stack_tos), 32'h00);
        clear(); push('hFF); push(1); do_req(BINOP_ADD, 1'b1);
        chk("add_wrap_tos", 32'(bus.stack_tos), 32'h00);

        clear(); push(7); do_req(BINOP_ADD, 1'b0);
        chk("uf1_status", 32'(bus.stack_status), 32'(STACK_ST_EMPTY));
        do_req(BINOP_ADD, 1'b1);
        chk("uf0_status", 32'(bus.stack_status), 32'(STACK_ST_UNDERFLOW));

        clear(); push(2); push(4); do_req(13, 1'b0);
        chk("badop_tos", 32'(bus.stack_tos), 32'h04);
        do_req(BINOP_XOR, 1'b0);
        chk("xor_after_bad", 32'(bus.stack_tos), 32'h06);

        // Reset while the sequencer sits in EVAL.
        clear(); push(4); push(6);
        req_kind = K_OK; req_res = 10; t0 = cyc + 1; req_active = 1'b1;
        bus.start = 1'b1; bus.opcode = 4'(BINOP_ADD);
        step();
        bus.start = 1'b0;
        step();
        reset = 1'b1;
        req_active = 1'b0;
        step();
        chk("rst_eval_busy", 32'(bus.busy), 32'd0);
        chk("rst_eval_done", 32'(bus.done), 32'd0);
        chk("rst_eval_op", 32'(bus.stack_op), 32'(STACK_OP_NONE));
        chk("rst_eval_status", 32'(bus.stack_status), 32'(STACK_ST_EMPTY));
        reset = 1'b0;
        q.delete();
        exp_st = STACK_ST_EMPTY;

        for (int it = 0; it < 80; it++) begin
            if ($urandom_range(0, 3) == 0) clear();
            n = $urandom_range(0, 2);
            while (q.size() < n) push($urandom_range(0, 255));
            do_req($urandom_range(0, 15), 1'($urandom_range(0, 1)));
        end

        step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/stack_binop.md
# stack_binop

Sequencer that executes one WebAssembly-style binary numeric instruction against the operand stack. It sits directly upstream of `stack`: it drives the stack's `op`/`data` inputs and reads back `tos`/`status`. It pops operand b, reads operand a from the new top, and overwrites a with the result (POP then REPLACE). The instruction decoder starts it and waits for `done`.

## Interface
- `WIDTH`, 8, operand/result width; must match the attached `stack` instance.
- `clk`  in  1  clock, shared with `stack`.
- `reset`  in  1  synchronous, active-high; clears state and all registered outputs.
- `start`  in  1  request; sampled only in IDLE.
- `opcode`  in  4  operation code from `binop.vh`; sampled with `start`.
- `busy`  out  1  high from the cycle after acceptance until `done` is asserted.
- `done`  out  1  one-cycle pulse; ends every accepted request, whether it succeeded or trapped.
- `trap`  out  2  valid while `done`=1, otherwise 0. Codes: `TRAP_NONE`=0, `TRAP_UNDERFLOW`=1, `TRAP_BADOP`=2.
- `stack_op`  out  2  to `stack.op`; uses `NONE`/`PUSH`/`POP`/`REPLACE` from `stack.vh`. This block never issues PUSH.
- `stack_data`  out  WIDTH  to `stack.data`.
- `stack_tos`  in  WIDTH  from `stack.tos`.
- `stack_status`  in  2  from `stack.status`.

## Operation
- States: IDLE, POP, EVAL, WRITE.
- IDLE:
  - `start`=1 with a valid opcode: latch the opcode; `b_reg` <= `stack_tos`; `stack_op` <= POP; go to POP.
  - `start`=1 with an invalid opcode: `done` <= 1, `trap` <= BADOP. No stack access; stay in IDLE.
- POP: the stack executes the pop on this edge. `stack_op` <= NONE; go to EVAL.
- EVAL: `stack_tos` and `stack_status` now reflect the pop.
  - `stack_status` is UNDERFLOW (stack was empty) or EMPTY (stack held one entry): `done` <= 1, `trap` <= UNDERFLOW, go to IDLE. The stack is left as-is; b is lost.
  - Otherwise: a = `stack_tos`; `stack_data` <= alu(a, b_reg); `stack_op` <= REPLACE; go to WRITE.
- WRITE: the stack executes the replace. `stack_op` <= NONE; `done` <= 1, `trap` <= NONE; go to IDLE.
- Opcodes (a op b), all results WIDTH bits, wrap-around, no overflow flag:
  - ADD=0: a+b. SUB=1: a-b.
  - AND=2, OR=3, XOR=4.
  - SHL=5, SHR_U=6, SHR_S=7: shift a by b mod WIDTH.
  - EQ=8, NE=9, LT_U=10, LT_S=11: result is 1 or 0, zero-extended.
  - Codes 12-15 are invalid (BADOP).
- `start` while `busy` is ignored, not queued.
- The stack sees exactly one POP and at most one REPLACE per request. `stack_op` is NONE at all other times.

## Timing
- Every output is a register. Reset values: state IDLE, `stack_op`=NONE, `stack_data`=0, `busy`=0, `done`=0, `trap`=0.
- Successful request, with edge E0 sampling `start`:
  - POP issued at E0 and executed at E1.
  - EVAL at E2.
  - REPLACE executed at E3.
  - `done` high from E3 to E4; result visible on `stack_tos` after E3.
- Trap timing:
  - Underflow trap: `done` high from E2 to E3.
  - BADOP: `done` high from E0 to E1.
- Back-to-back: a new `start` can be accepted on the edge where `done` is high, because the state is already IDLE.
- Reset mid-operation: the next edge forces IDLE and all registers to their reset values. No `done` is produced. Any stack op already executed is not undone. `stack` shares `reset` and clears too.

## Structure
- `binop.vh`: opcode macros (`BINOP_ADD` … `BINOP_LT_S`) and trap codes (`TRAP_*`).
- Reuse `stack.vh` for op and status codes; do not duplicate them.
- One sub-module, `binop_alu`: combinational; inputs (opcode, a, b); output result. Unit-testable alone.
- The top level is the FSM plus `b_reg`, the opcode latch and the output registers. Target ~150-250 lines total.

## Test plan
Bench uses `stack` WIDTH=8, DEPTH=1 (2 entries) and the shared `clk`/`reset`.
- Push 3, push 5; start SUB -> `done` at E3, `trap`=0, `tos`=8'hFE, `status`=NONE.
- Push 8'h80, push 1; start SHR_S -> `tos`=8'hC0. Repeat with SHR_U -> `tos`=8'h40. Shift amount 9 behaves as 1.
- Push 8'hFF, push 1; start LT_S -> `tos`=1. Repeat with LT_U -> `tos`=0. ADD of 8'hFF+1 -> `tos`=0.
- Push 7 only; start ADD -> `done` at E2, `trap`=UNDERFLOW, `status`=EMPTY, no REPLACE observed. Empty stack -> same trap, `status`=UNDERFLOW.
- Opcode 13 -> `done` at E0+1, `trap`=BADOP, `stack_op` stays NONE. `start` pulsed during `busy` -> ignored; exactly one `done`.
- Assert `reset` while in EVAL -> next cycle IDLE, `busy`=0, `done`=0, `stack_op`=NONE, `status`=EMPTY.
